pcpi_dispatch: RTL and testbench
================================

// Module: pcpi_dispatch
// PURPOSE
//  Upstream PCPI front-end for the custom-instruction coprocessors. Decodes CUSTOM-0 requests from the core's
//  PCPI port, holds pcpi_wait, and issues operands to a downstream execution unit (EXU) over valid/ready.
//  When the EXU result returns, it is driven back to the core as a one-cycle pcpi_ready/pcpi_wr pulse.
//  Multi-cycle EXUs can therefore replace the single-cycle register datapath.
// PARAMETERS
//  OPCODE          7'b0001011  insn[6:0] value claimed by this block
//  FUNCT7          7'b0000000  insn[31:25] value claimed by this block
//  TIMEOUT_CYCLES  64          max cycles in WAITR before forced completion; 0 disables the timeout
// PORTS
//  pcpi_clock     in   1   clock, all logic on rising edge
//  pcpi_resetn    in   1   asynchronous, active-low reset
//  pcpi_valid     in   1   core request; insn/rs1/rs2 stable while high
//  pcpi_insn      in   32  instruction word
//  pcpi_rs1       in   32  operand A
//  pcpi_rs2       in   32  operand B
//  pcpi_wr        out  1   write rd to register file (qualified by pcpi_ready)
//  pcpi_rd        out  32  result
//  pcpi_wait      out  1   instruction claimed, result pending
//  pcpi_ready     out  1   one-cycle completion pulse
//  exu_req_valid  out  1   operands valid to EXU
//  exu_req_ready  in   1   EXU accepts operands
//  exu_op         out  3   insn[14:12] (funct3) latched
//  exu_a          out  32  rs1 latched
//  exu_b          out  32  rs2 latched
//  exu_rsp_valid  in   1   EXU result valid
//  exu_rsp_data   in   32  EXU result
//  exu_rsp_ready  out  1   block accepts EXU result
//  timeout_err    out  1   one-cycle pulse on forced completion
// BEHAVIOUR
//  Reset (async, pcpi_resetn=0):
//   - state=IDLE, drain=0.
//   - All outputs 0, including pcpi_rd, exu_a, exu_b and exu_op.
//   - Reset mid-transaction abandons it; no pcpi_ready is issued.
//  match = pcpi_valid && insn[6:0]==OPCODE && insn[31:25]==FUNCT7. Non-matching insns are ignored entirely.
//  IDLE -> ISSUE when match && !drain.
//   - On that edge, latch exu_a/exu_b/exu_op and clear the timeout counter.
//  ISSUE:
//   - exu_req_valid=1; exu_a/exu_b/exu_op held stable.
//   - exu_req_ready=1 -> WAITR. No timeout here; valid is never withdrawn.
//  WAITR:
//   - exu_rsp_ready=1; counter increments each cycle.
//   - exu_rsp_valid=1 -> RESP; pcpi_rd<=exu_rsp_data; wr_q<=1.
//   - Else counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) -> RESP; pcpi_rd<=0; wr_q<=0; drain<=1; timeout_err pulses.
//   - Response and timeout in the same cycle: the response wins and drain stays 0.
//  RESP:
//   - pcpi_ready=1 and pcpi_wr=wr_q for exactly this cycle -> RECOVER.
//  RECOVER:
//   - One cycle in which pcpi_valid is ignored (the core drops valid late) -> IDLE.
//  Outputs and registers:
//   - pcpi_wait is registered: 1 in ISSUE and WAITR, 0 elsewhere. First high cycle is the one after the claim.
//   - pcpi_rd holds its last value outside RESP.
//  Abort rule:
//   - pcpi_valid falling in ISSUE/WAITR sets abort.
//   - The EXU handshakes still complete normally.
//   - RESP is then replaced by RECOVER with pcpi_ready=0 and pcpi_wr=0. abort clears in IDLE.
//  Drain:
//   - While drain=1, exu_rsp_ready=1 in every state.
//   - The first exu_rsp_valid while drain=1 is discarded and clears drain.
//   - IDLE claims nothing while drain=1.
//  Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1; it never wraps.
// TESTING
//  T1 insn=0x0000400B, rs1=5, rs2=3; EXU ready at once, returns 0x6 after 3 cycles:
//     wait high from cycle 1; ready+wr pulse with rd=0x6; exu_op=4, exu_a=5, exu_b=3.
//  T2 insn=0x00000033 (OP, not custom), valid held 20 cycles:
//     wait, ready, exu_req_valid all remain 0.
//  T3 exu_req_ready held low 10 cycles:
//     exu_req_valid and operands stable throughout; no timeout_err; then a normal completion.
//  T4 TIMEOUT_CYCLES=8, EXU never responds:
//     ready=1, wr=0, rd=0 and timeout_err pulse 8 cycles after WAITR entry.
//     A late response is consumed with no pcpi_ready; the next insn then completes normally.
//  T5 pcpi_resetn low during WAITR:
//     all outputs 0 immediately (async), IDLE next; a following insn completes normally.
//  T6 back-to-back insns with valid held one extra cycle after ready:
//     no double claim; second result correct.

Source files
------------

// File: rtl/pcpi_dispatch.sv
// pcpi_dispatch: PCPI front-end for custom-instruction coprocessors.
// Claims matching CUSTOM-0 instructions, forwards the operands to an execution unit
// over valid/ready, and returns the unit's result to the core as a one-cycle pulse.
module pcpi_dispatch #(
  parameter logic [6:0]  OPCODE         = 7'b0001011,
  parameter logic [6:0]  FUNCT7         = 7'b0000000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        pcpi_clock,
  input  logic        pcpi_resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        exu_req_valid,
  input  logic        exu_req_ready,
  output logic [2:0]  exu_op,
  output logic [31:0] exu_a,
  output logic [31:0] exu_b,
  input  logic        exu_rsp_valid,
  input  logic [31:0] exu_rsp_data,
  output logic        exu_rsp_ready,
  output logic        timeout_err
);

  localparam int unsigned CNT_W       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAITR,
    RESP,
    RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic               drain_q, drain_d;
  logic               abort_q, abort_d;
  logic               wr_q, wr_d;
  logic               take_rsp;
  logic               force_done;
  logic               match;
  logic               timeout_hit;
  logic [CNT_W-1:0]   cnt_q;
  logic               unused_insn_bits;

  assign match = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7);

  // The register/immediate fields of the instruction are not needed by this block.
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // Next-state, drain and abort decisions for the dispatch sequence.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    abort_d    = abort_q;
    wr_d       = wr_q;
    take_rsp   = 1'b0;
    force_done = 1'b0;

    // A stale response from a timed-out operation is swallowed here.
    if (drain_q && exu_rsp_valid) begin
      drain_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (match && !drain_q) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!pcpi_valid) begin
          abort_d = 1'b1;
        end
        if (exu_req_ready) begin
          state_d = WAITR;
        end
      end
      WAITR: begin
        if (!pcpi_valid) begin
          abort_d = 1'b1;
        end
        if (exu_rsp_valid) begin
          take_rsp = 1'b1;
          wr_d     = 1'b1;
          state_d  = abort_d ? RECOVER : RESP;
        end else if (timeout_hit) begin
          force_done = 1'b1;
          wr_d       = 1'b0;
          drain_d    = 1'b1;
          state_d    = abort_d ? RECOVER : RESP;
        end
      end
      RESP: begin
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath latches and registered outputs, all derived from the next state.
  always_ff @(posedge pcpi_clock or negedge pcpi_resetn) begin
    if (!pcpi_resetn) begin
      state_q       <= IDLE;
      drain_q       <= 1'b0;
      abort_q       <= 1'b0;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
      pcpi_wr       <= 1'b0;
      pcpi_rd       <= '0;
      pcpi_wait     <= 1'b0;
      pcpi_ready    <= 1'b0;
      exu_req_valid <= 1'b0;
      exu_op        <= '0;
      exu_a         <= '0;
      exu_b         <= '0;
      exu_rsp_ready <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      abort_q       <= abort_d;
      wr_q          <= wr_d;
      pcpi_wait     <= (state_d == ISSUE) || (state_d == WAITR);
      exu_req_valid <= (state_d == ISSUE);
      exu_rsp_ready <= (state_d == WAITR) || drain_d;
      pcpi_ready    <= (state_d == RESP);
      pcpi_wr       <= (state_d == RESP) && wr_d;
      timeout_err   <= force_done;

      if (take_rsp) begin
        pcpi_rd <= exu_rsp_data;
      end else if (force_done) begin
        pcpi_rd <= '0;
      end

      if ((state_q == IDLE) && (state_d == ISSUE)) begin
        exu_op <= pcpi_insn[14:12];
        exu_a  <= pcpi_rs1;
        exu_b  <= pcpi_rs2;
        cnt_q  <= '0;
      end else if ((state_q == WAITR) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// tb_pcpi_dispatch: directed scenarios for the PCPI dispatch front-end with a short timeout.
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        exu_req_valid;
  logic        exu_req_ready = 1'b0;
  logic [2:0]  exu_op;
  logic [31:0] exu_a;
  logic [31:0] exu_b;
  logic        exu_rsp_valid = 1'b0;
  logic [31:0] exu_rsp_data = '0;
  logic        exu_rsp_ready;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  pcpi_dispatch #(
    .OPCODE(7'b0001011),
    .FUNCT7(7'b0000000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pcpi_clock(clk),
    .pcpi_resetn(resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1),
    .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr),
    .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait),
    .pcpi_ready(pcpi_ready),
    .exu_req_valid(exu_req_valid),
    .exu_req_ready(exu_req_ready),
    .exu_op(exu_op),
    .exu_a(exu_a),
    .exu_b(exu_b),
    .exu_rsp_valid(exu_rsp_valid),
    .exu_rsp_data(exu_rsp_data),
    .exu_rsp_ready(exu_rsp_ready),
    .timeout_err(timeout_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [104:0] outs;
    resetn = 1'b0;
    tick();
    tick();
    outs = {pcpi_wr, pcpi_wait, pcpi_ready, exu_req_valid, exu_rsp_ready, timeout_err,
            exu_op, pcpi_rd, exu_a, exu_b};
    checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs); end
    resetn = 1'b1;
    tick();
    checks++; if (pcpi_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_wait: got %b expected 0", pcpi_wait); end
  endtask

  task automatic test_basic();
    exu_req_ready = 1'b1;
    issue(32'h0000400B, 32'd5, 32'd3);
    tick();
    checks++; if (pcpi_wait !== 1'b1) begin errors++; $display("[TB] FAIL t1_wait: got %b expected 1", pcpi_wait); end
    checks++; if (exu_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_req_valid: got %b expected 1", exu_req_valid); end
    checks++; if ({exu_op, exu_a, exu_b} !== {3'd4, 32'd5, 32'd3}) begin errors++; $display("[TB] FAIL t1_operands: got op=%0d a=%0d b=%0d expected op=4 a=5 b=3", exu_op, exu_a, exu_b); end
    tick();
    checks++; if ({exu_req_valid, exu_rsp_ready, pcpi_wait} !== 3'b011) begin errors++; $display("[TB] FAIL t1_waitr: got %b expected 011", {exu_req_valid, exu_rsp_ready, pcpi_wait}); end
    tick();
    tick();
    checks++; if (pcpi_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_early_ready: got %b expected 0", pcpi_ready); end
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h6;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b110) begin errors++; $display("[TB] FAIL t1_resp: got ready/wr/wait=%b expected 110", {pcpi_ready, pcpi_wr, pcpi_wait}); end
    checks++; if (pcpi_rd !== 32'h6) begin errors++; $display("[TB] FAIL t1_rd: got %h expected 00000006", pcpi_rd); end
    exu_rsp_valid = 1'b0;
    pcpi_valid    = 1'b0;
    tick();
    checks++; if (pcpi_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_pulse_width: got %b expected 0", pcpi_ready); end
    tick();
  endtask

  task automatic test_non_custom();
    logic seen;
    seen = 1'b0;
    issue(32'h00000033, 32'd1, 32'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | pcpi_wait | pcpi_ready | exu_req_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL t2_ignored: got activity=%b expected 0", seen); end
    pcpi_valid = 1'b0;
    tick();
  endtask

  task automatic test_issue_stall();
    logic bad;
    bad = 1'b0;
    exu_req_ready = 1'b0;
    issue(32'h0000100B, 32'hAAAA5555, 32'h12345678);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (exu_req_valid !== 1'b1 || timeout_err !== 1'b0 || pcpi_wait !== 1'b1 ||
          {exu_op, exu_a, exu_b} !== {3'd1, 32'hAAAA5555, 32'h12345678}) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL t3_stall_stable: got bad=%b expected 0", bad); end
    exu_req_ready = 1'b1;
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'hDEADBEEF;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, timeout_err} !== 3'b110) begin errors++; $display("[TB] FAIL t3_resp: got ready/wr/terr=%b expected 110", {pcpi_ready, pcpi_wr, timeout_err}); end
    checks++; if (pcpi_rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL t3_rd: got %h expected deadbeef", pcpi_rd); end
    exu_rsp_valid = 1'b0;
    pcpi_valid    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    exu_req_ready = 1'b1;
    issue(32'h0000700B, 32'd1, 32'd2);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (pcpi_ready !== 1'b0 || timeout_err !== 1'b0 || pcpi_wait !== 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL t4_early_timeout: got %b expected 0", early); end
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, timeout_err} !== 3'b101) begin errors++; $display("[TB] FAIL t4_forced: got ready/wr/terr=%b expected 101", {pcpi_ready, pcpi_wr, timeout_err}); end
    checks++; if (pcpi_rd !== 32'h0) begin errors++; $display("[TB] FAIL t4_rd_zero: got %h expected 00000000", pcpi_rd); end
    pcpi_valid = 1'b0;
    tick();
    checks++; if ({timeout_err, exu_rsp_ready} !== 2'b01) begin errors++; $display("[TB] FAIL t4_drain_ready: got terr/rsp_ready=%b expected 01", {timeout_err, exu_rsp_ready}); end
    tick();
    issue(32'h0000200B, 32'd10, 32'd20);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pcpi_wait !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL t4_claim_while_drain: got %b expected 0", early); end
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h5555;
    tick();
    checks++; if ({pcpi_ready, pcpi_wait, exu_rsp_ready} !== 3'b000) begin errors++; $display("[TB] FAIL t4_late_consumed: got ready/wait/rsp_ready=%b expected 000", {pcpi_ready, pcpi_wait, exu_rsp_ready}); end
    exu_rsp_valid = 1'b0;
    tick();
    checks++; if ({pcpi_wait, exu_op, exu_a, exu_b} !== {1'b1, 3'd2, 32'd10, 32'd20}) begin errors++; $display("[TB] FAIL t4_next_claim: got wait=%b op=%0d a=%0d b=%0d expected 1 2 10 20", pcpi_wait, exu_op, exu_a, exu_b); end
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'd30;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_rd} !== {2'b11, 32'd30}) begin errors++; $display("[TB] FAIL t4_next_resp: got ready=%b wr=%b rd=%h expected 1 1 0000001e", pcpi_ready, pcpi_wr, pcpi_rd); end
    exu_rsp_valid = 1'b0;
    pcpi_valid    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    exu_req_ready = 1'b1;
    issue(32'h0000100B, 32'd1, 32'd1);
    tick();
    tick();
    pcpi_valid = 1'b0;
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h99;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b000) begin errors++; $display("[TB] FAIL abort_no_ready: got ready/wr/wait=%b expected 000", {pcpi_ready, pcpi_wr, pcpi_wait}); end
    exu_rsp_valid = 1'b0;
    tick();
    checks++; if (pcpi_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 0", pcpi_ready); end
  endtask

  task automatic test_back_to_back();
    exu_req_ready = 1'b1;
    issue(32'h0000500B, 32'd9, 32'd4);
    tick();
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h11;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_rd} !== {2'b11, 32'h11}) begin errors++; $display("[TB] FAIL t6_first: got ready=%b wr=%b rd=%h expected 1 1 00000011", pcpi_ready, pcpi_wr, pcpi_rd); end
    exu_rsp_valid = 1'b0;
    tick();
    checks++; if ({pcpi_ready, pcpi_wait} !== 2'b00) begin errors++; $display("[TB] FAIL t6_recover: got ready/wait=%b expected 00", {pcpi_ready, pcpi_wait}); end
    issue(32'h0000600B, 32'd100, 32'd200);
    tick();
    checks++; if (pcpi_wait !== 1'b0) begin errors++; $display("[TB] FAIL t6_no_double_claim: got %b expected 0", pcpi_wait); end
    tick();
    checks++; if ({pcpi_wait, exu_op, exu_a, exu_b} !== {1'b1, 3'd6, 32'd100, 32'd200}) begin errors++; $display("[TB] FAIL t6_second_claim: got wait=%b op=%0d a=%0d b=%0d expected 1 6 100 200", pcpi_wait, exu_op, exu_a, exu_b); end
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h22;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_rd} !== {2'b11, 32'h22}) begin errors++; $display("[TB] FAIL t6_second: got ready=%b wr=%b rd=%h expected 1 1 00000022", pcpi_ready, pcpi_wr, pcpi_rd); end
    exu_rsp_valid = 1'b0;
    pcpi_valid    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [104:0] outs;
    exu_req_ready = 1'b1;
    issue(32'h0000300B, 32'd7, 32'd8);
    tick();
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    outs = {pcpi_wr, pcpi_wait, pcpi_ready, exu_req_valid, exu_rsp_ready, timeout_err,
            exu_op, pcpi_rd, exu_a, exu_b};
    checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL t5_async_clear: got %h expected 0", outs); end
    tick();
    resetn = 1'b1;
    checks++; if (pcpi_ready !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_ready: got %b expected 0", pcpi_ready); end
    tick();
    checks++; if ({pcpi_wait, exu_op, exu_a, exu_b} !== {1'b1, 3'd3, 32'd7, 32'd8}) begin errors++; $display("[TB] FAIL t5_reclaim: got wait=%b op=%0d a=%0d b=%0d expected 1 3 7 8", pcpi_wait, exu_op, exu_a, exu_b); end
    tick();
    exu_rsp_valid = 1'b1;
    exu_rsp_data  = 32'h77;
    tick();
    checks++; if ({pcpi_ready, pcpi_wr, pcpi_rd} !== {2'b11, 32'h77}) begin errors++; $display("[TB] FAIL t5_resp: got ready=%b wr=%b rd=%h expected 1 1 00000077", pcpi_ready, pcpi_wr, pcpi_rd); end
    exu_rsp_valid = 1'b0;
    pcpi_valid    = 1'b0;
    tick();
    tick();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_basic();
    test_non_custom();
    test_issue_stall();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
